// File: rtl/dfx_pkg.sv
// Shared types and defaults for the DFX decouple controller.
// The state encoding is visible on state_o, so it is fixed here.
package dfx_pkg;

  typedef enum logic [2:0] {
    ST_COUPLED   = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_ASSERT    = 3'd2,
    ST_DECOUPLED = 3'd3,
    ST_RELEASE   = 3'd4
  } dfx_state_e;

  localparam int DFX_CNT_W       = 6;
  localparam int DFX_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/dfx_outstanding_cnt.sv
// Saturating up/down counter of outstanding transactions.
// err_o pulses when an increment hits all-ones or a decrement hits zero.
module dfx_outstanding_cnt
  import dfx_pkg::*;
#(
  parameter int CNT_W = DFX_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && inc_i && !dec_i) begin
      if (&cnt_q) err = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end else if (en_i && dec_i && !inc_i) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign err_o = err;

endmodule

// File: rtl/dfx_decouple_ctrl.sv
// Sequences a DFX decoupler: hold masters, drain outstanding AXI traffic,
// assert decouple, and release on request; drain is bounded by a timeout.
module dfx_decouple_ctrl
  import dfx_pkg::*;
#(
  parameter int CNT_W       = DFX_CNT_W,
  parameter int TIMEOUT_CYC = DFX_TIMEOUT_CYC
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_decouple_i,
  output logic       decouple_o,
  input  logic       decouple_status_i,
  output logic       hold_o,
  input  logic       i0_aw_hs_i,
  input  logic       i0_b_hs_i,
  input  logic       i0_ar_hs_i,
  input  logic       i0_r_hs_i,
  input  logic       i1_aw_hs_i,
  input  logic       i1_b_hs_i,
  input  logic       i1_ar_hs_i,
  input  logic       i1_r_hs_i,
  input  logic       i1_rlast_i,
  output logic [2:0] state_o,
  output logic       timeout_o,
  output logic       overflow_o
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  dfx_state_e       state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             decouple_q, decouple_d;
  logic             hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic             overflow_q, overflow_d;
  logic             clr_cnt;
  logic             all_zero;
  logic [3:0]       inc, dec, err;
  logic [CNT_W-1:0] cnt_w [4];

  // Index order: wr0, rd0, wr1, rd1. An i1 read only retires on its last beat.
  assign inc = {i1_ar_hs_i, i1_aw_hs_i, i0_ar_hs_i, i0_aw_hs_i};
  assign dec = {i1_r_hs_i & i1_rlast_i, i1_b_hs_i, i0_r_hs_i, i0_b_hs_i};

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    dfx_outstanding_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (!decouple_q),
      .clr_i (clr_cnt),
      .inc_i (inc[g]),
      .dec_i (dec[g]),
      .cnt_o (cnt_w[g]),
      .err_o (err[g])
    );
  end

  assign all_zero = (cnt_w[0] == '0) && (cnt_w[1] == '0) &&
                    (cnt_w[2] == '0) && (cnt_w[3] == '0);

  always_comb begin
    state_d   = state_q;
    tcnt_d    = '0;
    timeout_d = timeout_q;
    clr_cnt   = 1'b0;
    case (state_q)
      ST_COUPLED: if (req_decouple_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!req_decouple_i) begin
          state_d = ST_COUPLED;
        end else if (all_zero) begin
          state_d = ST_ASSERT;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_ASSERT;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      // The decoupler swallows whatever was still in flight.
      ST_ASSERT: if (decouple_status_i) begin
        state_d = ST_DECOUPLED;
        clr_cnt = 1'b1;
      end
      ST_DECOUPLED: if (!req_decouple_i) state_d = ST_RELEASE;
      ST_RELEASE: if (!decouple_status_i) begin
        state_d   = ST_COUPLED;
        timeout_d = 1'b0;
      end
      default: state_d = ST_COUPLED;
    endcase
    decouple_d = (state_d == ST_ASSERT) || (state_d == ST_DECOUPLED);
    hold_d     = (state_d != ST_COUPLED);
    overflow_d = overflow_q | (|err);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_COUPLED;
      tcnt_q     <= '0;
      decouple_q <= 1'b0;
      hold_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      decouple_q <= decouple_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  assign decouple_o = decouple_q;
  assign hold_o     = hold_q;
  assign state_o    = state_q;
  assign timeout_o  = timeout_q;
  assign overflow_o = overflow_q;

endmodule
